// File: rtl/count_uart_tx.sv
// Captures an 8-bit count into a one-entry holding buffer and transmits it as an 8N1 UART frame.
// A capture happens on a change of i_count_in, or on a rising edge of i_send_req.
module count_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_count_in,
  input  logic       i_send_mode,
  input  logic       i_send_req,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overrun,
  output logic [7:0] o_frames_sent
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [11:0] LastCnt = 12'(CLKS_PER_BIT - 1);

  state_e      r_state;
  logic [11:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_frames;
  logic        r_tx;

  logic [7:0]  r_hold_data;
  logic        r_hold_valid;
  logic [7:0]  r_last_seen;
  logic        r_req_q;
  logic        r_overrun;

  logic        w_event;
  logic        w_drain;
  logic        w_bit_end;

  assign w_event   = i_send_mode ? (i_send_req & ~r_req_q) : (i_count_in != r_last_seen);
  assign w_drain   = (r_state == StIdle) & r_hold_valid;
  assign w_bit_end = (r_bit_cnt == LastCnt);

  // Holding buffer; an event coinciding with a drain refills it without flagging overrun.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold_data  <= 8'h00;
      r_hold_valid <= 1'b0;
      r_last_seen  <= 8'h00;
      r_req_q      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_last_seen <= i_count_in;
      r_req_q     <= i_send_req;
      if (w_event) begin
        r_hold_data  <= i_count_in;
        r_hold_valid <= 1'b1;
        if (r_hold_valid && !w_drain) begin
          r_overrun <= 1'b1;
        end
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Transmit FSM; r_tx is updated together with the state so the line level leads the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_tx      <= 1'b1;
      r_bit_cnt <= 12'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_frames  <= 8'h00;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= 12'd0;
          if (r_hold_valid) begin
            r_shift <= r_hold_data;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_bit_cnt <= 12'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= StData;
          end else begin
            r_bit_cnt <= r_bit_cnt + 12'd1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_bit_cnt <= 12'd0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 12'd1;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_bit_cnt <= 12'd0;
            r_frames  <= r_frames + 8'd1;
            r_state   <= StIdle;
          end else begin
            r_bit_cnt <= r_bit_cnt + 12'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_tx          = r_tx;
  assign o_busy        = (r_state != StIdle) | r_hold_valid;
  assign o_overrun     = r_overrun;
  assign o_frames_sent = r_frames;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed and randomized checks of count_uart_tx with CLKS_PER_BIT = 4.
// Expected line waveforms are built from the 8N1 framing rule.
module tb_count_uart_tx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned FrameCycles = 10 * Cpb;

  logic       clk;
  logic       rst_n;
  logic [7:0] count_in;
  logic       send_mode;
  logic       send_req;
  logic       tx;
  logic       busy;
  logic       overrun;
  logic [7:0] frames_sent;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int bad;
  int gap;
  logic [7:0]  exp_frames;
  logic [7:0]  d;
  logic [39:0] wave;

  count_uart_tx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_count_in   (count_in),
    .i_send_mode  (send_mode),
    .i_send_req   (send_req),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Ideal line level over one frame: start bit, data LSB first, stop bit.
  function automatic logic [39:0] frame_wave(input logic [7:0] data);
    logic [9:0]  bits;
    logic [39:0] w;
    bits = {1'b1, data, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = bits[i / Cpb];
    return w;
  endfunction

  task automatic wait_start(input int already, output int cycles);
    cycles = already;
    while (tx !== 1'b0 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic capture_from(input int from);
    for (int i = from; i < FrameCycles; i++) begin
      wave[i] = tx;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_frames = 8'h00;
  endtask

  task automatic quiet(input int cycles, input string tag);
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      step();
    end
    check(tag, 40'(bad), 40'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    count_in = 8'h00;
    send_mode = 1'b0;
    send_req = 1'b0;
    exp_frames = 8'h00;
    wave = '0;

    // Reset with arbitrary inputs
    count_in = 8'($urandom);
    send_mode = 1'($urandom);
    send_req = 1'($urandom);
    rst_n = 1'b0;
    step();
    step();
    check("rst_tx", 40'(tx), 40'd1);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_overrun", 40'(overrun), 40'd0);
    check("rst_frames", 40'(frames_sent), 40'd0);
    count_in = 8'h00;
    send_mode = 1'b0;
    send_req = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle", 40'({tx, busy}), 40'b10);

    // Requested send of 0xA5
    send_mode = 1'b1;
    count_in = 8'hA5;
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    check("req_busy_early", 40'({tx, busy}), 40'b11);
    wait_start(1, lat);
    check("req_latency", 40'(lat), 40'd2);
    capture_from(0);
    check("req_frame_a5", wave, frame_wave(8'hA5));
    exp_frames = exp_frames + 8'd1;
    check("req_busy_done", 40'(busy), 40'd0);
    check("req_frames", 40'(frames_sent), 40'(exp_frames));

    // send_req held high for 100 cycles gives a single frame
    d = 8'($urandom);
    count_in = d;
    send_req = 1'b1;
    wait_start(0, lat);
    check("hold_latency", 40'(lat), 40'd2);
    capture_from(0);
    check("hold_frame", wave, frame_wave(d));
    exp_frames = exp_frames + 8'd1;
    quiet(100 - lat - FrameCycles, "hold_single_frame");
    check("hold_frames", 40'(frames_sent), 40'(exp_frames));
    send_req = 1'b0;
    step();

    // Change-triggered send
    send_mode = 1'b0;
    count_in = 8'h00;
    do_reset();
    quiet(3, "chg_no_event");
    count_in = 8'h01;
    wait_start(0, lat);
    check("chg_latency", 40'(lat), 40'd2);
    capture_from(0);
    check("chg_frame_01", wave, frame_wave(8'h01));
    exp_frames = exp_frames + 8'd1;
    quiet(30, "chg_quiet");
    check("chg_frames", 40'(frames_sent), 40'(exp_frames));

    // Overrun and simultaneous drain
    count_in = 8'h00;
    do_reset();
    step();
    step();
    count_in = 8'h10;
    step();
    count_in = 8'h11;
    step();
    check("ovr_start_tx", 40'(tx), 40'd0);
    check("ovr_drain_no_ovr", 40'(overrun), 40'd0);
    wave = '0;
    wave[0] = tx;
    count_in = 8'h12;
    step();
    check("ovr_set", 40'(overrun), 40'd1);
    capture_from(1);
    check("ovr_frame_10", wave, frame_wave(8'h10));
    exp_frames = exp_frames + 8'd1;
    check("ovr_gap_idle", 40'({tx, busy}), 40'b11);
    step();
    check("ovr_b2b_start", 40'(tx), 40'd0);
    capture_from(0);
    check("ovr_frame_12", wave, frame_wave(8'h12));
    exp_frames = exp_frames + 8'd1;
    check("ovr_frames", 40'(frames_sent), 40'(exp_frames));
    check("ovr_sticky", 40'(overrun), 40'd1);
    check("ovr_busy_done", 40'(busy), 40'd0);

    // Reset during data bit 3 of a 0xFF frame
    send_mode = 1'b1;
    do_reset();
    check("rst2_clears_overrun", 40'(overrun), 40'd0);
    count_in = 8'hFF;
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    wait_start(1, lat);
    check("mid_latency", 40'(lat), 40'd2);
    repeat (17) step();
    check("mid_in_data", 40'({tx, busy}), 40'b11);
    rst_n = 1'b0;
    step();
    check("mid_rst_tx", 40'(tx), 40'd1);
    check("mid_rst_busy", 40'(busy), 40'd0);
    check("mid_rst_frames", 40'(frames_sent), 40'd0);
    step();
    rst_n = 1'b1;
    quiet(60, "mid_no_resume");
    check("mid_frames_after", 40'(frames_sent), 40'd0);

    // 256 requested frames with random data and gaps
    do_reset();
    for (int f = 0; f < 256; f++) begin
      d = 8'($urandom);
      count_in = d;
      send_req = 1'b1;
      step();
      send_req = 1'b0;
      count_in = 8'($urandom);
      wait_start(1, lat);
      check("wrap_latency", 40'(lat), 40'd2);
      capture_from(0);
      check("wrap_frame", wave, frame_wave(d));
      exp_frames = exp_frames + 8'd1;
      check("wrap_count", 40'(frames_sent), 40'(exp_frames));
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
    end
    check("wrap_zero", 40'(frames_sent), 40'h00);
    check("wrap_no_overrun", 40'(overrun), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
